io_hub: RTL and testbench

//  Parametrised memory-mapped IO hub between the core's IO bus and the board peripherals.

---
 rtl/io_hub_pkg.sv | 16 +
 rtl/io_hub_fifo.sv | 49 ++++
 rtl/io_hub.sv | 181 ++++++++++++++++++
 tb/tb_io_hub.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/io_hub_pkg.sv
// Shared constants for io_hub: register byte offsets, STATUS bit positions, channel limit.
package io_hub_pkg;

  localparam int unsigned MAX_CH = 8;

  localparam int unsigned OUT_BASE   = 32'h00;
  localparam int unsigned IN_BASE    = 32'h20;
  localparam int unsigned STATUS_OFF = 32'h40;
  localparam int unsigned MASK_OFF   = 32'h44;

  localparam int unsigned ST_NON_EMPTY_LSB = MAX_CH;
  localparam int unsigned ST_WR_DROP       = 16;
  localparam int unsigned ST_RD_EMPTY      = 17;
  localparam int unsigned MASK_ERR_BIT     = 31;

endpackage

// File: rtl/io_hub_fifo.sv
// Synchronous FIFO for one io_hub input channel; push into full and pop from empty are ignored.
module io_hub_fifo #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally since the depth is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/io_hub.sv
// Memory-mapped IO hub: NUM_OUT 1-deep output channels, NUM_IN FIFO input channels, STATUS.
// Optional interrupt logic and IRQ_MASK register are built when IO_HUB_IRQ_EN is defined.
module io_hub
  import io_hub_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned NUM_OUT    = 2,
  parameter int unsigned NUM_IN     = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_W-1:0]         io_addr,
  input  logic [DATA_W-1:0]         io_dout,
  input  logic                      io_we,
  input  logic                      io_rd,
  output logic [DATA_W-1:0]         io_din,
  output logic [NUM_OUT*DATA_W-1:0] out_data,
  output logic [NUM_OUT-1:0]        out_valid,
  input  logic [NUM_OUT-1:0]        out_ready,
  input  logic [NUM_IN*DATA_W-1:0]  in_data,
  input  logic [NUM_IN-1:0]         in_valid,
  output logic [NUM_IN-1:0]         in_ready,
  input  logic [ADDR_W-1:0]         chk_addr,
  output logic [DATA_W-1:0]         chk_data
`ifdef IO_HUB_IRQ_EN
  ,
  output logic                      irq
`endif
);

  localparam int unsigned WA_W = ADDR_W - 2;

  logic [WA_W-1:0]    io_wa;
  logic [WA_W-1:0]    chk_wa;
  logic [NUM_OUT-1:0] out_hit;
  logic [NUM_OUT-1:0] out_acc;
  logic [NUM_IN-1:0]  in_hit;
  logic [NUM_IN-1:0]  fifo_push;
  logic [NUM_IN-1:0]  fifo_pop;
  logic [NUM_IN-1:0]  fifo_full;
  logic [NUM_IN-1:0]  fifo_empty;
  logic [DATA_W-1:0]  fifo_head [NUM_IN];
  logic [DATA_W-1:0]  status_word;
  logic               wr_drop;
  logic               rd_empty;
  logic               wr_drop_set;
  logic               rd_empty_set;
  logic               status_wr;
  logic               unused_addr_bits;

  assign io_wa            = io_addr[ADDR_W-1:2];
  assign chk_wa           = chk_addr[ADDR_W-1:2];
  assign unused_addr_bits = ^{io_addr[1:0], chk_addr[1:0]};

  function automatic logic is_word(input logic [WA_W-1:0] wa, input int unsigned byte_off);
    return wa == WA_W'(byte_off >> 2);
  endfunction

  // Address decode and side-effect qualifiers for the current core access.
  always_comb begin
    out_hit = '0;
    out_acc = '0;
    in_hit  = '0;
    for (int unsigned k = 0; k < NUM_OUT; k++) begin
      out_hit[k] = io_we & is_word(io_wa, OUT_BASE + 4 * k);
      out_acc[k] = out_hit[k] & (~out_valid[k] | out_ready[k]);
    end
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      in_hit[k] = io_rd & is_word(io_wa, IN_BASE + 4 * k);
    end
  end

  assign fifo_push    = in_valid & ~fifo_full;
  assign fifo_pop     = in_hit & ~fifo_empty;
  assign in_ready     = ~fifo_full;
  assign wr_drop_set  = |(out_hit & ~out_acc);
  assign rd_empty_set = |(in_hit & fifo_empty);
  assign status_wr    = io_we & is_word(io_wa, STATUS_OFF);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= '0;
      out_data  <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_OUT; k++) begin
        if (out_acc[k]) begin
          out_data[k*DATA_W +: DATA_W] <= io_dout;
          out_valid[k]                 <= 1'b1;
        end else if (out_valid[k] & out_ready[k]) begin
          out_valid[k] <= 1'b0;
        end
      end
    end
  end

  // Sticky error flags: a new error in the same cycle as a W1C clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_drop  <= 1'b0;
      rd_empty <= 1'b0;
    end else begin
      if (wr_drop_set)                         wr_drop <= 1'b1;
      else if (status_wr & io_dout[ST_WR_DROP]) wr_drop <= 1'b0;
      if (rd_empty_set)                          rd_empty <= 1'b1;
      else if (status_wr & io_dout[ST_RD_EMPTY]) rd_empty <= 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_IN; g++) begin : g_in
    io_hub_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push[g]),
      .pop   (fifo_pop[g]),
      .wdata (in_data[g*DATA_W +: DATA_W]),
      .head  (fifo_head[g]),
      .full  (fifo_full[g]),
      .empty (fifo_empty[g])
    );
  end

  always_comb begin
    status_word                              = '0;
    status_word[NUM_OUT-1:0]                 = out_valid;
    status_word[ST_NON_EMPTY_LSB +: NUM_IN]  = ~fifo_empty;
    status_word[ST_WR_DROP]                  = wr_drop;
    status_word[ST_RD_EMPTY]                 = rd_empty;
  end

`ifdef IO_HUB_IRQ_EN
  logic [NUM_IN-1:0] mask_in;
  logic              mask_err;
  logic [DATA_W-1:0] mask_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_in  <= '0;
      mask_err <= 1'b0;
      irq      <= 1'b0;
    end else begin
      if (io_we & is_word(io_wa, MASK_OFF)) begin
        mask_in  <= io_dout[NUM_IN-1:0];
        mask_err <= io_dout[MASK_ERR_BIT];
      end
      irq <= |(~fifo_empty & mask_in) | (mask_err & (wr_drop | rd_empty));
    end
  end

  always_comb begin
    mask_word               = '0;
    mask_word[NUM_IN-1:0]   = mask_in;
    mask_word[MASK_ERR_BIT] = mask_err;
  end
`endif

  // Pure readback mux shared by the core port and the debug port; no side effects here.
  function automatic logic [DATA_W-1:0] read_word(input logic [WA_W-1:0] wa);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int unsigned k = 0; k < NUM_OUT; k++) begin
      if (is_word(wa, OUT_BASE + 4 * k)) r = out_data[k*DATA_W +: DATA_W];
    end
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (is_word(wa, IN_BASE + 4 * k) && !fifo_empty[k]) r = fifo_head[k];
    end
    if (is_word(wa, STATUS_OFF)) r = status_word;
`ifdef IO_HUB_IRQ_EN
    if (is_word(wa, MASK_OFF)) r = mask_word;
`endif
    return r;
  endfunction

  always_comb io_din   = read_word(io_wa);
  always_comb chk_data = read_word(chk_wa);

endmodule

// File: tb/tb_io_hub.sv
// Randomized self-checking bench for io_hub against a queue-based behavioural model.
module tb_io_hub;

  localparam int NO = 2;
  localparam int NI = 2;
  localparam int D  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  addr, caddr;
  logic [31:0] dout;
  logic        we, rd;
  logic [1:0]  oready, ivalid;
  logic [63:0] idata;
  logic [31:0] io_din, chk_data;
  logic [63:0] out_data;
  logic [1:0]  out_valid, in_ready;
`ifdef IO_HUB_IRQ_EN
  logic        irq;
  logic [1:0]  m_mask;
  logic        m_merr;
  logic        m_irq;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // Model state
  logic [31:0] m_data [NO];
  logic [1:0]  m_valid;
  logic [31:0] mq [NI][$];
  logic        m_drop, m_empt;

  always #5 clk = ~clk;

  io_hub dut (
    .clk(clk), .rst(rst), .io_addr(addr), .io_dout(dout), .io_we(we), .io_rd(rd),
    .io_din(io_din), .out_data(out_data), .out_valid(out_valid), .out_ready(oready),
    .in_data(idata), .in_valid(ivalid), .in_ready(in_ready),
    .chk_addr(caddr), .chk_data(chk_data)
`ifdef IO_HUB_IRQ_EN
    , .irq(irq)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_valid = '0;
    for (int k = 0; k < NO; k++) m_data[k] = '0;
    for (int k = 0; k < NI; k++) mq[k].delete();
    m_drop = 1'b0;
    m_empt = 1'b0;
`ifdef IO_HUB_IRQ_EN
    m_mask = '0; m_merr = 1'b0; m_irq = 1'b0;
`endif
  endtask

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s = '0;
    s[1:0] = m_valid;
    for (int k = 0; k < NI; k++) s[8+k] = (mq[k].size() > 0);
    s[16] = m_drop;
    s[17] = m_empt;
    return s;
  endfunction

  function automatic logic [31:0] model_read(input logic [7:0] a);
    int wa;
    wa = int'(a >> 2);
    if (wa < NO) return m_data[wa];
    if (wa >= 8 && wa < 8 + NI) return (mq[wa-8].size() > 0) ? mq[wa-8][0] : 32'h0;
    if (wa == 16) return model_status();
`ifdef IO_HUB_IRQ_EN
    if (wa == 17) return {m_merr, 29'h0, m_mask};
`endif
    return 32'h0;
  endfunction

  task automatic model_update();
    int wa;
    logic drop, empt;
    logic [1:0] can_push;
`ifdef IO_HUB_IRQ_EN
    logic irq_next;
    irq_next = 1'b0;
    for (int k = 0; k < NI; k++) if (mq[k].size() > 0 && m_mask[k]) irq_next = 1'b1;
    if (m_merr && (m_drop || m_empt)) irq_next = 1'b1;
`endif
    wa = int'(addr >> 2);
    drop = 1'b0;
    empt = 1'b0;
    for (int k = 0; k < NI; k++) can_push[k] = (mq[k].size() < D);
    for (int k = 0; k < NO; k++) begin
      if (we && wa == k) begin
        if (!m_valid[k] || oready[k]) begin
          m_data[k]  = dout;
          m_valid[k] = 1'b1;
        end else drop = 1'b1;
      end else if (m_valid[k] && oready[k]) m_valid[k] = 1'b0;
    end
    for (int k = 0; k < NI; k++) begin
      if (rd && wa == 8 + k) begin
        if (mq[k].size() > 0) void'(mq[k].pop_front());
        else empt = 1'b1;
      end
      if (ivalid[k] && can_push[k]) mq[k].push_back(idata[k*32 +: 32]);
    end
    if (we && wa == 16) begin
      if (dout[16]) m_drop = 1'b0;
      if (dout[17]) m_empt = 1'b0;
    end
    if (drop) m_drop = 1'b1;
    if (empt) m_empt = 1'b1;
`ifdef IO_HUB_IRQ_EN
    if (we && wa == 17) begin
      m_mask = dout[1:0];
      m_merr = dout[31];
    end
    m_irq = irq_next;
`endif
  endtask

  // Compare all outputs with the model, advance the model and the DUT by one clock.
  task automatic step();
    logic [1:0] exp_rdy;
    #1;
    for (int k = 0; k < NI; k++) exp_rdy[k] = (mq[k].size() < D);
    check("io_din", io_din, model_read(addr));
    check("chk_data", chk_data, model_read(caddr));
    check("out_valid", {30'h0, out_valid}, {30'h0, m_valid});
    check("in_ready", {30'h0, in_ready}, {30'h0, exp_rdy});
    check("out_data0", out_data[31:0], m_data[0]);
    check("out_data1", out_data[63:32], m_data[1]);
`ifdef IO_HUB_IRQ_EN
    check("irq", {31'h0, irq}, {31'h0, m_irq});
`endif
    if (rst) model_reset();
    else model_update();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] addr_pool [10];

  initial begin
    addr_pool = '{8'h00, 8'h04, 8'h08, 8'h20, 8'h24, 8'h28, 8'h40, 8'h44, 8'h3c, 8'h80};
    rst = 1'b1; we = 1'b0; rd = 1'b0; addr = '0; caddr = 8'h40; dout = '0;
    oready = '0; ivalid = '0; idata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();

    // Reset state
    check("rst out_valid", {30'h0, out_valid}, 32'h0);
    check("rst in_ready", {30'h0, in_ready}, 32'h3);
    check("rst status", chk_data, 32'h0);

    // Output channel accept, drop on busy, drain
    addr = 8'h00; dout = 32'h1234; we = 1'b1; step();
    check("t2 valid", {31'h0, out_valid[0]}, 32'h1);
    check("t2 data", out_data[31:0], 32'h1234);
    dout = 32'h5678; step();
    we = 1'b0; #1;
    check("t2 status", chk_data, 32'h0001_0001);
    check("t2 data kept", out_data[31:0], 32'h1234);
    oready = 2'b01; step(); oready = 2'b00;
    check("t2 drain", {31'h0, out_valid[0]}, 32'h0);

    // Fill ch1, overflow ignored, drain in order, read-empty sticky, W1C
    ivalid = 2'b10;
    for (int v = 5; v <= 8; v++) begin idata[63:32] = v; step(); end
    check("t3 full", {31'h0, in_ready[1]}, 32'h0);
    idata[63:32] = 9; step(); ivalid = '0;
    addr = 8'h24; rd = 1'b1;
    for (int i = 0; i < 4; i++) begin #1; check("t3 rd", io_din, 32'(5 + i)); step(); end
    #1; check("t3 rd empty", io_din, 32'h0); step(); rd = 1'b0;
    check("t3 sticky", chk_data, 32'h0003_0000);
    addr = 8'h40; dout = 32'h0003_0000; we = 1'b1; step(); we = 1'b0;
    check("t3 clear", chk_data, 32'h0);

    // Full FIFO push+pop -> pop only; empty FIFO push+pop -> push only
    ivalid = 2'b10;
    for (int v = 10; v <= 13; v++) begin idata[63:32] = v; step(); end
    check("t4 full", {31'h0, in_ready[1]}, 32'h0);
    idata[63:32] = 14; addr = 8'h24; rd = 1'b1;
    #1; check("t4 pop", io_din, 32'd10); step(); ivalid = '0;
    for (int v = 11; v <= 13; v++) begin #1; check("t4 drain", io_din, 32'(v)); step(); end
    ivalid = 2'b10; idata[63:32] = 32'h77;
    #1; check("t4 empty rd", io_din, 32'h0); step();
    ivalid = '0; rd = 1'b0; caddr = 8'h24; #1;
    check("t4 retained", chk_data, 32'h77);

    // Debug readback never pops
    ivalid = 2'b01; idata[31:0] = 32'hAB; step(); ivalid = '0; caddr = 8'h20; addr = 8'h00;
    for (int i = 0; i < 10; i++) begin step(); check("t5 chk", chk_data, 32'hAB); end

`ifdef IO_HUB_IRQ_EN
    rst = 1'b1; step(); rst = 1'b0;
    addr = 8'h44; dout = 32'h2; we = 1'b1; step(); we = 1'b0;
    ivalid = 2'b10; idata[63:32] = 32'h99; step(); ivalid = '0;
    check("t6 irq lag", {31'h0, irq}, 32'h0);
    step();
    check("t6 irq on", {31'h0, irq}, 32'h1);
    addr = 8'h24; rd = 1'b1; step(); rd = 1'b0; step();
    check("t6 irq off", {31'h0, irq}, 32'h0);
`endif

    // Randomized traffic including occasional mid-transfer reset
    for (int c = 0; c < 800; c++) begin
      addr   = addr_pool[$urandom_range(0, 9)] | 8'($urandom_range(0, 3));
      caddr  = addr_pool[$urandom_range(0, 9)];
      dout   = $urandom;
      if ($urandom_range(0, 3) == 0) dout[17:16] = 2'($urandom_range(0, 3));
      we     = ($urandom_range(0, 2) == 0);
      rd     = ($urandom_range(0, 2) == 0);
      oready = 2'($urandom_range(0, 3));
      ivalid = 2'($urandom_range(0, 3));
      idata  = {32'($urandom), 32'($urandom)};
      rst    = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0; we = 1'b0; rd = 1'b0; ivalid = '0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
